// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Holds no adder: every iteration drives the shared ALU and folds its result back into HI/LO working registers.
module mdu_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] src_a,
  input  logic [N-1:0] src_b,
  input  logic [N-1:0] alu_y,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_f,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NEG_A  = 3'd1;
  localparam logic [2:0] S_NEG_B  = 3'd2;
  localparam logic [2:0] S_LOOP   = 3'd3;
  localparam logic [2:0] S_FIX_LO = 3'd4;
  localparam logic [2:0] S_FIX_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [2:0] F_ADD  = 3'b010;
  localparam logic [2:0] F_SUB  = 3'b110;
  localparam logic [2:0] F_ANDN = 3'b100;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic [N-1:0]  wh_q, wh_d;   // P_hi or remainder
  logic [N-1:0]  wl_q, wl_d;   // P_lo or quotient
  logic [N-1:0]  m_q, m_d;     // multiplicand or divisor
  logic [N-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic          dz_q, dz_d, done_q, done_d, busy_q, busy_d;
  logic [N-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_f_q, alu_f_d;
  logic          carry_c, bb_msb_c, take_c, ld_res_c;

  // Carry out of the shared ALU, reconstructed from operand and result MSBs.
  assign bb_msb_c = alu_f_q[2] ? ~alu_b_q[N-1] : alu_b_q[N-1];
  assign carry_c  = (alu_a_q[N-1] & bb_msb_c) | ((alu_a_q[N-1] | bb_msb_c) & ~alu_y[N-1]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_f_d  = F_ADD;
    take_c   = 1'b0;
    ld_res_c = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d  = op;
          sa_d  = op[0] & src_a[N-1];
          sb_d  = op[0] & src_b[N-1];
          dz_d  = 1'b0;
          cnt_d = '0;
          wh_d  = '0;
          wl_d  = op[1] ? src_a : src_b;
          m_d   = op[1] ? src_b : src_a;
          if (op[1] && (src_b == '0)) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
            hi_d    = src_a;
            lo_d    = '1;
          end else if (op[0]) begin
            state_d = S_NEG_A;
          end else begin
            state_d = S_LOOP;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_NEG_A: begin
        if (sa_q) begin
          if (op_q[1]) wl_d = alu_y;
          else         m_d  = alu_y;
        end
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        if (sb_q) begin
          if (op_q[1]) m_d  = alu_y;
          else         wl_d = alu_y;
        end
        state_d = S_LOOP;
      end
      S_LOOP: begin
        if (op_q[1]) begin
          take_c = wh_q[N-1] | carry_c;
          wh_d   = take_c ? alu_y : {wh_q[N-2:0], wl_q[N-1]};
          wl_d   = {wl_q[N-2:0], take_c};
        end else if (wl_q[0]) begin
          wh_d = {carry_c, alu_y[N-1:1]};
          wl_d = {alu_y[0], wl_q[N-1:1]};
        end else begin
          wh_d = {1'b0, wh_q[N-1:1]};
          wl_d = {wh_q[0], wl_q[N-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          ld_res_c = ~op_q[0];
          state_d  = op_q[0] ? S_FIX_LO : S_DONE;
        end
      end
      S_FIX_LO: begin
        if (sa_q ^ sb_q) wl_d = alu_y;
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        if (op_q[1] ? sa_q : (sa_q ^ sb_q)) wh_d = alu_y;
        ld_res_c = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (ld_res_c) begin
      hi_d = wh_d;
      lo_d = wl_d;
    end

    // ALU drive is registered, so it is decoded from next-state values.
    case (state_d)
      S_NEG_A: begin
        alu_b_d = op_d[1] ? wl_d : m_d;
        alu_f_d = F_SUB;
      end
      S_NEG_B: begin
        alu_b_d = op_d[1] ? m_d : wl_d;
        alu_f_d = F_SUB;
      end
      S_LOOP: begin
        alu_b_d = m_d;
        if (op_d[1]) begin
          alu_a_d = {wh_d[N-2:0], wl_d[N-1]};
          alu_f_d = F_SUB;
        end else begin
          alu_a_d = wh_d;
          alu_f_d = F_ADD;
        end
      end
      S_FIX_LO: begin
        alu_b_d = wl_d;
        alu_f_d = F_SUB;
      end
      S_FIX_HI: begin
        alu_b_d = wh_d;
        // A nonzero low word absorbs the +1, so the high word is only inverted.
        if (!op_d[1] && (wl_d != '0)) begin
          alu_a_d = '1;
          alu_f_d = F_ANDN;
        end else begin
          alu_f_d = F_SUB;
        end
      end
      default: ;
    endcase

    busy_d = (state_d == S_NEG_A) || (state_d == S_NEG_B) || (state_d == S_LOOP) ||
             (state_d == S_FIX_LO) || (state_d == S_FIX_HI);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      wh_q    <= '0;
      wl_q    <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_f_q <= F_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_f_q <= alu_f_d;
    end
  end

  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_f = alu_f_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dz    = dz_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: models the shared ALU, runs a vector table and random ops
// through a scoreboard, plus hand sequences for mid-op start, reset and back-to-back starts.
module tb_mdu_sequencer;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [N-1:0] src_a, src_b, alu_y, alu_a, alu_b, hi, lo;
  logic [2:0]   alu_f;
  logic         busy, done, dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[11];

  mdu_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .alu_y(alu_y), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Shared ALU model.
  always_comb begin
    case (alu_f)
      3'b010:  alu_y = alu_a + alu_b;
      3'b110:  alu_y = alu_a - alu_b;
      3'b100:  alu_y = alu_a & ~alu_b;
      default: alu_y = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    vec_t   v;
    longint pa, pb, p;
    logic [63:0] u;
    v.op = o; v.a = a; v.b = b; v.dz = 1'b0;
    pa = $signed(a);
    pb = $signed(b);
    v.lat = o[0] ? 37 : 33;
    case (o)
      2'b00: begin u = {32'h0, a} * {32'h0, b}; v.hi = u[63:32]; v.lo = u[31:0]; end
      2'b01: begin p = pa * pb; u = p; v.hi = u[63:32]; v.lo = u[31:0]; end
      default: begin
        if (b == 0) begin
          v.hi = a; v.lo = '1; v.dz = 1'b1; v.lat = 1;
        end else if (o == 2'b10) begin
          v.lo = a / b; v.hi = a % b;
        end else begin
          p = pa / pb; u = p; v.lo = u[31:0];
          p = pa % pb; u = p; v.hi = u[31:0];
        end
      end
    endcase
    return v;
  endfunction

  // Waits for done counting cycles from the accept edge; optionally pulses start mid-op.
  task automatic wait_done(input int pulse_at);
    int   n  = 1;
    int   bc = 0;
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: no expected entry, got none");
      return;
    end
    e = exp_q.pop_front();
    chk("dz_at_accept", dz, e.dz);
    while (!done && n < 200) begin
      if (busy) bc++;
      if (n == pulse_at) begin
        start = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: op=%0d a=0x%0h b=0x%0h, no done after %0d cycles", e.op, e.a, e.b, n);
      return;
    end
    chk("latency", 64'(n), 64'(e.lat));
    chk("busy_cycles", 64'(bc), 64'(e.lat - 1));
    chk("hi", hi, e.hi);
    chk("lo", lo, e.lo);
    chk("dz", dz, e.dz);
  endtask

  task automatic issue(input vec_t v);
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input vec_t v, input int pulse_at);
    issue(v);
    wait_done(pulse_at);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'd7,         32'd6,         32'h0,         32'h2A,        1'b0, 33};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h1,         1'b0, 33};
    vecs[2]  = '{2'b01, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF,  32'hFFFFFFF1,  1'b0, 37};
    vecs[3]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0,         32'h1,         1'b0, 37};
    vecs[4]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[5]  = '{2'b11, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  1'b0, 37};
    vecs[6]  = '{2'b11, 32'd7,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFD,  1'b0, 37};
    vecs[7]  = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  1'b1, 1};
    vecs[8]  = '{2'b11, 32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000,  1'b0, 37};
    vecs[9]  = '{2'b11, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  32'hFFFFFFFF,  1'b1, 1};
    vecs[10] = '{2'b00, 32'd0,         32'd12345,     32'h0,         32'h0,         1'b0, 33};

    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", dz, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_f", alu_f, 3'b010);

    foreach (vecs[i]) run(vecs[i], 0);

    // Random operations against the bench model, including divide-by-zero.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom);
      if (i == 0) begin ro = 2'b11; rb = 32'h0; end
      run(model(ro, ra, rb), 0);
    end

    // start pulsed mid-LOOP must be ignored.
    run(vecs[0], 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ignored_start_done", done, 1'b0);
      chk("ignored_start_dz", dz, 1'b0);
    end

    // Back-to-back: start while in DONE, result held until the next DONE.
    run(vecs[0], 0);
    exp_q.push_back(vecs[4]);
    start = 1'b1; op = vecs[4].op; src_a = vecs[4].a; src_b = vecs[4].b;
    @(negedge clk);
    start = 1'b0;
    chk("chain_done_low", done, 1'b0);
    chk("chain_busy", busy, 1'b1);
    chk("chain_hi_hold", hi, 32'h0);
    chk("chain_lo_hold", lo, 32'h2A);
    begin
      int   n = 1;
      vec_t e;
      while (!done && n < 200) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      chk("chain_latency", 64'(n), 64'(e.lat));
      chk("chain_hi", hi, e.hi);
      chk("chain_lo", lo, e.lo);
    end

    // Reset at cycle 10 of a multiply aborts it.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd1000; src_b = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    run(vecs[1], 0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
